// File: rtl/test_ctrl_responder.sv
// End-of-test responder: a req/gnt/rvalid register port holding exit code, scratch,
// cycle counter and watchdog, driving the eoc/timeout flags the harness waits on.
module test_ctrl_responder #(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter logic [AddrWidth-1:0] BaseAddr       = '0,
    parameter logic [31:0]          DefaultTimeout = 32'd1000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   eoc_o,
    output logic [DataWidth-2:0]   exit_code_o,
    output logic                   timeout_o,
    output logic [DataWidth-1:0]   cycle_o
);
    // Terminal states own one bit each so eoc_o/timeout_o come straight off the state flops.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DONE    = 2'b01,
        ST_TIMEOUT = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        REG_EXIT    = 3'd0,
        REG_SCRATCH = 3'd1,
        REG_CYCLE   = 3'd2,
        REG_TIMEOUT = 3'd3,
        REG_STATUS  = 3'd4
    } reg_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   cycle_q, cycle_d;
    logic [DataWidth-1:0]   scratch_q, scratch_d;
    logic [DataWidth-1:0]   timeout_q, timeout_d;
    logic [DataWidth-2:0]   exit_code_q, exit_code_d;
    logic                   rvalid_q, rvalid_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [AddrWidth-1:0]   offset;
    reg_e                   reg_idx;
    logic                   req_err;
    logic                   running;
    logic                   wd_hit;
    logic                   exit_hit;

    function automatic logic [DataWidth-1:0] apply_be(
        input logic [DataWidth-1:0]   old_val,
        input logic [DataWidth-1:0]   new_val,
        input logic [DataWidth/8-1:0] be
    );
        logic [DataWidth-1:0] res;
        res = old_val;
        for (int b = 0; b < DataWidth / 8; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign offset  = addr_i - BaseAddr;
    assign reg_idx = reg_e'(offset[4:2]);
    assign running = (state_q == ST_RUN);

    always_comb begin
        req_err = (offset > AddrWidth'(16)) || (offset[1:0] != 2'b00);
        case (reg_idx)
            REG_EXIT:               if (we_i && be_i != '1) req_err = 1'b1;
            REG_CYCLE, REG_STATUS:  if (we_i) req_err = 1'b1;
            default:                ;
        endcase
    end

    // Equality only: a TIMEOUT written at or below the current count never fires.
    assign wd_hit   = running && (timeout_q != '0) && (cycle_q == timeout_q - DataWidth'(1));
    assign exit_hit = req_i && we_i && !req_err && (reg_idx == REG_EXIT) && running && wdata_i[0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        scratch_d   = scratch_q;
        timeout_d   = timeout_q;
        exit_code_d = exit_code_q;
        rvalid_d    = req_i;
        rdata_d     = '0;
        err_d       = 1'b0;

        if (running && cycle_q != '1) cycle_d = cycle_q + DataWidth'(1);

        if (req_i) begin
            err_d = req_err;
            if (!req_err) begin
                if (we_i) begin
                    case (reg_idx)
                        REG_SCRATCH: scratch_d = apply_be(scratch_q, wdata_i, be_i);
                        REG_TIMEOUT: timeout_d = apply_be(timeout_q, wdata_i, be_i);
                        default:     ;
                    endcase
                end else begin
                    case (reg_idx)
                        REG_EXIT:    rdata_d = {exit_code_q, eoc_o};
                        REG_SCRATCH: rdata_d = scratch_q;
                        REG_CYCLE:   rdata_d = cycle_q;
                        REG_TIMEOUT: rdata_d = timeout_q;
                        REG_STATUS:  rdata_d = {{(DataWidth-2){1'b0}}, timeout_o, eoc_o};
                        default:     ;
                    endcase
                end
            end
        end

        // A same-cycle exit report beats watchdog expiry.
        if (exit_hit) begin
            state_d     = ST_DONE;
            exit_code_d = wdata_i[DataWidth-1:1];
        end else if (wd_hit) begin
            state_d = ST_TIMEOUT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            scratch_q   <= '0;
            timeout_q   <= DefaultTimeout;
            exit_code_q <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            scratch_q   <= scratch_d;
            timeout_q   <= timeout_d;
            exit_code_q <= exit_code_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign gnt_o       = req_i && !rst_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign eoc_o       = state_q[0];
    assign timeout_o   = state_q[1];
    assign exit_code_o = exit_code_q;
    assign cycle_o     = cycle_q;

endmodule

// File: doc/test_ctrl_responder.md
Name: test_ctrl_responder

Overview:
Memory-mapped end-of-test responder inside the testharness. Software running on the cluster issues requests to it over a req/gnt/rvalid register port. Through that port software reports an exit code, uses a scratch register, and reads a cycle counter. The block drives the end-of-computation and timeout flags that the top-level bench samples to stop simulation, so the bench no longer relies on a fixed time budget.

Parameters:
AddrWidth, 32, request address width
DataWidth, 32, data width (fixed 32; other values unsupported)
BaseAddr, 32'h0000_0000, base of the 32-byte register window
DefaultTimeout, 32'd1000, reset value of TIMEOUT register in cycles; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  1  request valid
gnt_o  out  1  request granted
addr_i  in  AddrWidth  byte address
we_i  in  1  1=write, 0=read
wdata_i  in  32  write data
be_i  in  4  byte enables
rvalid_o  out  1  response valid, exactly 1 cycle
rdata_o  out  32  read data (0 on writes and errors)
err_o  out  1  response error, qualified by rvalid_o
eoc_o  out  1  end of computation reported
exit_code_o  out  31  reported exit code
timeout_o  out  1  watchdog expired
cycle_o  out  32  current cycle counter

Behaviour:
- Reset (async assert, sync deassert at clk_i edge):
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, eoc_o=0, exit_code_o=0, timeout_o=0, cycle_o=0.
  - SCRATCH=0, TIMEOUT=DefaultTimeout, state=RUN.
  - A pending response is discarded; no rvalid_o follows a reset.
- Handshake:
  - gnt_o = req_i, combinational, in every state after reset.
  - Response arrives exactly 1 cycle after the grant cycle, as a rvalid_o pulse.
  - Back-to-back requests give back-to-back responses; there is no backpressure.
- Decode (offset = addr_i - BaseAddr):
  - 0x00 EXIT: read returns {exit_code, eoc}.
  - 0x04 SCRATCH: RW, byte-enable masked.
  - 0x08 CYCLE: RO counter value.
  - 0x0C TIMEOUT: RW, byte-enable masked.
  - 0x10 STATUS: RO, {30'b0, timeout, eoc}.
- Errors: err_o=1 and no state change for any of the following:
  - offset outside 0x00-0x10;
  - addr_i[1:0] != 0;
  - a write to CYCLE or STATUS;
  - a write to EXIT with be_i != 4'hF.
- EXIT write with wdata[0]=1 in state RUN:
  - next cycle: eoc_o=1, exit_code_o=wdata[31:1], state -> DONE.
  - A write with wdata[0]=0 is accepted with no effect.
- State machine, RUN -> DONE | TIMEOUT:
  - DONE and TIMEOUT are terminal until reset.
  - In terminal states, EXIT writes are accepted (err_o=0) but ignored; the first exit code is sticky.
  - Other registers stay fully accessible in terminal states.
- Cycle counter:
  - Increments by 1 every cycle in RUN and saturates at 32'hFFFF_FFFF.
  - Frozen in DONE/TIMEOUT.
  - A read returns the value at the grant cycle.
- Watchdog:
  - Fires when TIMEOUT != 0 and the counter equals TIMEOUT-1 in RUN.
  - Next cycle: state -> TIMEOUT, timeout_o=1.
  - Writing TIMEOUT to a value <= the current counter never fires; the comparison is equality only.
  - TIMEOUT=0 disables it.
- Simultaneous: if an EXIT write and watchdog expiry occur in the same cycle, EXIT wins (state DONE, timeout_o stays 0).
- All outputs are registered except gnt_o.

Test Plan:
- Reset, then hold rst_i=1 for 3 cycles -> all outputs 0, TIMEOUT read (after release) = 1000.
- Write 0x04=0xDEADBEEF be=4'hF, then write 0x04=0x000000AA be=4'b0001, then read 0x04 -> first response err_o=0 next cycle; read returns 0xDEADBEAA.
- Write EXIT=0x0000_0001 at cycle 50, then write EXIT=0x0000_0007 -> eoc_o=1, exit_code_o=0 (first value sticks); CYCLE read stays frozen at 51; STATUS=0x1.
- TIMEOUT=20 written just after reset, no EXIT -> timeout_o=1 once counter reaches 19; eoc_o=0; STATUS=0x2; cycle_o frozen.
- Read 0x14, read 0x02, write 0x08, write EXIT be=4'h1 -> four consecutive 1-cycle rvalid_o pulses, each err_o=1, rdata_o=0, no flag change.
- Set TIMEOUT so that expiry coincides with the EXIT write cycle; separately assert rst_i while a read is granted -> eoc_o=1, timeout_o=0; no rvalid_o after the reset.
